cpu_seq: RTL and testbench

Parametrised multicycle sequencer for the simple RISC datapath. It decodes `opcode`/`op` from the instruction register and drives the datapath, PC and memory control strobes. It supersedes the fixed controller with a true registered state, configurable memory latency on fetch and load/store, an optional memory-ready handshake, and a HALT state. It sits between the instruction register and the datapath/RAM in the CPU top level.

---
 rtl/cpu_seq.sv | 181 ++++++++++++++++++
 tb/tb_cpu_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq.sv
// cpu_seq: multicycle Moore sequencer for the simple RISC datapath with MEM_WAIT memory dwell.
// Optional feature: define CPU_SEQ_MEM_READY_EN to gate FETCH/MEM completion on mem_ready.
module cpu_seq #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_ready,
    output logic       loadir,
    output logic       incp,
    output logic       tsel,
    output logic       execb,
    output logic       msel,
    output logic       mwrite,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       asel,
    output logic       bsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        S_FETCH = 4'd1,
        S_LDIR  = 4'd2,
        S_INCPC = 4'd3,
        S_RDRN  = 4'd4,
        S_RDRM  = 4'd5,
        S_WRRN  = 4'd6,
        S_CALC  = 4'd7,
        S_STAT  = 4'd8,
        S_MEM   = 4'd9,
        S_WRRD  = 4'd10,
        S_RDRD  = 4'd11,
        S_EXBR  = 4'd12,
        S_EXBM  = 4'd13,
        S_HALT  = 4'd14
    } state_e;

    localparam logic [3:0] WAIT_C = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_ok;
    logic       dwell_done;

`ifdef CPU_SEQ_MEM_READY_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    assign dwell_done = (cnt_q == WAIT_C) && mem_ok;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: if (dwell_done) state_d = S_LDIR;
            S_LDIR:  state_d = S_INCPC;
            S_INCPC: begin
                case (opcode)
                    3'b110:         state_d = (op == 2'b10) ? S_WRRN : S_RDRM;
                    3'b101:         state_d = (op == 2'b11) ? S_RDRM : S_RDRN;
                    3'b011, 3'b100: state_d = S_RDRN;
                    3'b001:         state_d = S_EXBR;
                    default:        state_d = S_HALT;
                endcase
            end
            S_RDRN:  state_d = (opcode == 3'b101) ? S_RDRM : S_CALC;
            S_RDRM:  state_d = S_CALC;
            S_CALC: begin
                if ({opcode, op} == 5'b101_01)
                    state_d = S_STAT;
                else if (opcode == 3'b011)
                    state_d = S_MEM;
                else if (opcode == 3'b100)
                    state_d = S_RDRD;
                else
                    state_d = S_WRRD;
            end
            S_RDRD:  state_d = S_MEM;
            S_MEM:   if (dwell_done) state_d = (opcode == 3'b011) ? S_WRRD : S_FETCH;
            S_WRRN, S_WRRD, S_STAT: state_d = S_FETCH;
            S_EXBR:  state_d = S_EXBM;
            S_EXBM:  state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Count only while dwelling; leaving or being outside FETCH/MEM clears it for the next entry.
    always_comb begin
        cnt_d = 4'd0;
        if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
            cnt_d = (cnt_q == WAIT_C) ? cnt_q : cnt_q + 4'd1;
    end

    always_comb begin
        loadir = 1'b0;
        incp   = 1'b0;
        tsel   = 1'b0;
        execb  = 1'b0;
        msel   = 1'b0;
        mwrite = 1'b0;
        nsel   = 2'b00;
        vsel   = 2'b00;
        write  = 1'b0;
        asel   = 1'b0;
        bsel   = 1'b0;
        loada  = 1'b0;
        loadb  = 1'b0;
        loadc  = 1'b0;
        loads  = 1'b0;
        halted = 1'b0;
        case (state_q)
            S_LDIR:  loadir = 1'b1;
            S_INCPC: incp = 1'b1;
            S_RDRN:  loada = 1'b1;
            S_RDRM: begin
                nsel  = 2'b10;
                loadb = 1'b1;
            end
            S_WRRN: begin
                vsel  = 2'b01;
                write = 1'b1;
            end
            S_CALC: begin
                loadc = 1'b1;
                bsel  = (opcode == 3'b011) || (opcode == 3'b100);
                asel  = (opcode == 3'b110);
            end
            S_STAT:  loads = 1'b1;
            S_MEM: begin
                msel   = 1'b1;
                mwrite = (opcode == 3'b100);
            end
            S_WRRD: begin
                nsel  = 2'b01;
                write = 1'b1;
                vsel  = (opcode == 3'b011) ? 2'b00 : 2'b11;
            end
            S_RDRD: begin
                nsel  = 2'b01;
                loadb = 1'b1;
            end
            S_EXBR: begin
                execb = 1'b1;
                tsel  = 1'b1;
            end
            S_EXBM:  tsel = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed bench for cpu_seq; three instances with MEM_WAIT = 0, 1, 2 share all inputs.
module tb_cpu_seq;

    typedef struct packed {
        logic       loadir, incp, tsel, execb, msel, mwrite;
        logic [1:0] nsel, vsel;
        logic       write, asel, bsel, loada, loadb, loadc, loads, halted;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       mem_ready = 1'b1;

    logic [2:0] loadir_w, incp_w, tsel_w, execb_w, msel_w, mwrite_w;
    logic [2:0] write_w, asel_w, bsel_w, loada_w, loadb_w, loadc_w, loads_w, halted_w;
    logic [1:0] nsel_w [3];
    logic [1:0] vsel_w [3];
    logic [3:0] st [3];
    ctl_t       ob [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cpu_seq #(.MEM_WAIT(g)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .opcode   (opcode),
            .op       (op),
            .mem_ready(mem_ready),
            .loadir   (loadir_w[g]),
            .incp     (incp_w[g]),
            .tsel     (tsel_w[g]),
            .execb    (execb_w[g]),
            .msel     (msel_w[g]),
            .mwrite   (mwrite_w[g]),
            .nsel     (nsel_w[g]),
            .vsel     (vsel_w[g]),
            .write    (write_w[g]),
            .asel     (asel_w[g]),
            .bsel     (bsel_w[g]),
            .loada    (loada_w[g]),
            .loadb    (loadb_w[g]),
            .loadc    (loadc_w[g]),
            .loads    (loads_w[g]),
            .halted   (halted_w[g]),
            .state    (st[g])
        );
        assign ob[g] = {loadir_w[g], incp_w[g], tsel_w[g], execb_w[g], msel_w[g], mwrite_w[g],
                        nsel_w[g], vsel_w[g], write_w[g], asel_w[g], bsel_w[g], loada_w[g],
                        loadb_w[g], loadc_w[g], loads_w[g], halted_w[g]};
    end

    // Expected control word for a state code, straight from the state/output table.
    function automatic ctl_t exp_out(input logic [3:0] s, input logic [2:0] opc);
        ctl_t c;
        c = '0;
        case (s)
            4'd2:  c.loadir = 1'b1;
            4'd3:  c.incp = 1'b1;
            4'd4:  c.loada = 1'b1;
            4'd5:  begin c.nsel = 2'b10; c.loadb = 1'b1; end
            4'd6:  begin c.vsel = 2'b01; c.write = 1'b1; end
            4'd7:  begin
                c.loadc = 1'b1;
                c.bsel  = (opc == 3'b011) || (opc == 3'b100);
                c.asel  = (opc == 3'b110);
            end
            4'd8:  c.loads = 1'b1;
            4'd9:  begin c.msel = 1'b1; c.mwrite = (opc == 3'b100); end
            4'd10: begin
                c.nsel  = 2'b01;
                c.write = 1'b1;
                c.vsel  = (opc == 3'b011) ? 2'b00 : 2'b11;
            end
            4'd11: begin c.nsel = 2'b01; c.loadb = 1'b1; end
            4'd12: begin c.execb = 1'b1; c.tsel = 1'b1; end
            4'd13: c.tsel = 1'b1;
            4'd14: c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Reset pulse with the instruction bits already applied; the next negedge sees FETCH.
    task automatic start_instr(input logic [2:0] opc, input logic [1:0] o);
        @(negedge clk);
        reset  = 1'b0;
        opcode = opc;
        op     = o;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (st[i] !== 4'd0 || ob[i] !== ctl_t'(0)) begin
                    n_err++;
                    $display("FAIL reset_hold dut%0d cyc%0d: state %0d ctl %h, want 0 / 0", i, k, st[i], ob[i]);
                end
            end
        end
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (st[i] !== 4'd1 || ob[i] !== ctl_t'(0)) begin
                n_err++;
                $display("FAIL reset_release dut%0d: state %0d ctl %h, want 1 / 0", i, st[i], ob[i]);
            end
        end
    endtask

    task automatic test_mov_imm();
        logic [27:0] seq0, seq2;
        logic [3:0]  e0, e2;
        seq0 = 28'h1236123;
        seq2 = 28'h1112361;
        start_instr(3'b110, 2'b10);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            e0 = seq0[4*(6-k) +: 4];
            e2 = seq2[4*(6-k) +: 4];
            n_vec++;
            if (st[0] !== e0 || ob[0] !== exp_out(e0, 3'b110)) begin
                n_err++;
                $display("FAIL mov_imm w0 cyc%0d: state %0d ctl %h, want %0d / %h", k, st[0], ob[0], e0, exp_out(e0, 3'b110));
            end
            n_vec++;
            if (st[2] !== e2 || ob[2] !== exp_out(e2, 3'b110)) begin
                n_err++;
                $display("FAIL mov_imm w2 cyc%0d: state %0d ctl %h, want %0d / %h", k, st[2], ob[2], e2, exp_out(e2, 3'b110));
            end
        end
    endtask

    task automatic test_ldr();
        logic [47:0] seq;
        logic [3:0]  e;
        seq = 48'h1112_3479_99A1;
        start_instr(3'b011, 2'b00);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            e = seq[4*(11-k) +: 4];
            n_vec++;
            if (st[2] !== e || ob[2] !== exp_out(e, 3'b011)) begin
                n_err++;
                $display("FAIL ldr w2 cyc%0d: state %0d ctl %h, want %0d / %h", k, st[2], ob[2], e, exp_out(e, 3'b011));
            end
        end
    endtask

    task automatic test_str();
        logic [39:0] seq;
        logic [3:0]  e;
        seq = 40'h11_2347_B991;
        start_instr(3'b100, 2'b00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            e = seq[4*(9-k) +: 4];
            n_vec++;
            if (st[1] !== e || ob[1] !== exp_out(e, 3'b100)) begin
                n_err++;
                $display("FAIL str w1 cyc%0d: state %0d ctl %h, want %0d / %h", k, st[1], ob[1], e, exp_out(e, 3'b100));
            end
        end
        // Abort a store mid-MEM: mwrite must fall with reset, not at the next edge.
        start_instr(3'b100, 2'b00);
        repeat (8) @(negedge clk);
        n_vec++;
        if (st[1] !== 4'd9 || mwrite_w[1] !== 1'b1) begin
            n_err++;
            $display("FAIL str_abort_pre: state %0d mwrite %b, want 9 / 1", st[1], mwrite_w[1]);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (st[1] !== 4'd0 || mwrite_w[1] !== 1'b0) begin
            n_err++;
            $display("FAIL str_abort_async: state %0d mwrite %b, want 0 / 0", st[1], mwrite_w[1]);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_alu();
        logic [4:0]  instr [4];
        logic [31:0] seqs [4];
        logic [3:0]  e;
        instr[0] = 5'b101_01; seqs[0] = 32'h1234_5781;
        instr[1] = 5'b101_00; seqs[1] = 32'h1234_57A1;
        instr[2] = 5'b101_11; seqs[2] = 32'h1235_7A12;
        instr[3] = 5'b110_00; seqs[3] = 32'h1235_7A12;
        for (int i = 0; i < 4; i++) begin
            start_instr(instr[i][4:2], instr[i][1:0]);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                e = seqs[i][4*(7-k) +: 4];
                n_vec++;
                if (st[0] !== e || ob[0] !== exp_out(e, instr[i][4:2])) begin
                    n_err++;
                    $display("FAIL alu %b w0 cyc%0d: state %0d ctl %h, want %0d / %h",
                             instr[i], k, st[0], ob[0], e, exp_out(e, instr[i][4:2]));
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [23:0] seq;
        logic [3:0]  e;
        seq = 24'h123CD1;
        start_instr(3'b001, 2'b00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = seq[4*(5-k) +: 4];
            n_vec++;
            if (st[0] !== e || ob[0] !== exp_out(e, 3'b001)) begin
                n_err++;
                $display("FAIL branch w0 cyc%0d: state %0d ctl %h, want %0d / %h", k, st[0], ob[0], e, exp_out(e, 3'b001));
            end
        end
    endtask

    task automatic test_halt();
        logic [23:0] seq;
        logic [3:0]  e;
        start_instr(3'b111, 2'b00);
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            e = (k < 3) ? 4'(k + 1) : 4'd14;
            n_vec++;
            if (st[0] !== e || ob[0] !== exp_out(e, 3'b111)) begin
                n_err++;
                $display("FAIL halt111 w0 cyc%0d: state %0d ctl %h, want %0d / %h", k, st[0], ob[0], e, exp_out(e, 3'b111));
            end
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (st[0] !== 4'd0 || halted_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL halt_exit: state %0d halted %b, want 0 / 0", st[0], halted_w[0]);
        end
        seq = 24'h11_23EE;
        start_instr(3'b010, 2'b01);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = seq[4*(5-k) +: 4];
            n_vec++;
            if (st[1] !== e || ob[1] !== exp_out(e, 3'b010)) begin
                n_err++;
                $display("FAIL halt010 w1 cyc%0d: state %0d ctl %h, want %0d / %h", k, st[1], ob[1], e, exp_out(e, 3'b010));
            end
        end
    endtask

    task automatic test_mem_ready();
`ifdef CPU_SEQ_MEM_READY_EN
        mem_ready = 1'b0;
        start_instr(3'b110, 2'b10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (st[0] !== 4'd1) begin
                n_err++;
                $display("FAIL ready_stall cyc%0d: state %0d, want 1", k, st[0]);
            end
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (st[0] !== 4'd2) begin
            n_err++;
            $display("FAIL ready_release: state %0d, want 2", st[0]);
        end
        mem_ready = 1'b0;
        start_instr(3'b110, 2'b10);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (st[0] !== 4'd0) begin
            n_err++;
            $display("FAIL ready_reset_mid_stall: state %0d, want 0", st[0]);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        reset     = 1'b1;
`else
        logic [15:0] seq;
        logic [3:0]  e;
        seq = 16'h1236;
        mem_ready = 1'b0;
        start_instr(3'b110, 2'b10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = seq[4*(3-k) +: 4];
            n_vec++;
            if (st[0] !== e) begin
                n_err++;
                $display("FAIL ready_ignored cyc%0d: state %0d, want %0d", k, st[0], e);
            end
        end
        mem_ready = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_ldr();
        test_str();
        test_alu();
        test_branch();
        test_halt();
        test_mem_ready();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
